// File: rtl/ps2_led_cmd_sequencer_pkg.sv
// Shared PS/2 byte codes, lock-key scancodes and LED-sequencer FSM encodings.
package ps2_led_cmd_sequencer_pkg;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_ACK          = 8'hFA;
  localparam logic [7:0] PS2_RESEND       = 8'hFE;

  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_SEND_CMD     = 3'd1;
  localparam logic [2:0] ST_WAIT_TX_CMD  = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK_CMD = 3'd3;
  localparam logic [2:0] ST_SEND_LED     = 3'd4;
  localparam logic [2:0] ST_WAIT_TX_LED  = 3'd5;
  localparam logic [2:0] ST_WAIT_ACK_LED = 3'd6;

  // LED bit flipped by a lock-key make code, laid out as {caps,num,scroll}.
  function automatic logic [2:0] lock_key_mask(input logic [7:0] code);
    case (code)
      SC_CAPS:   lock_key_mask = 3'b100;
      SC_NUM:    lock_key_mask = 3'b010;
      SC_SCROLL: lock_key_mask = 3'b001;
      default:   lock_key_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// Saturating cycle counter that flags when LIMIT cycles have elapsed since the last clear.
module ps2_timeout_timer #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ps2_led_cmd_sequencer.sv
// Keeps keyboard lock LEDs in sync with lock-key presses by running the PS/2 Set-LEDs
// exchange (0xED, ACK, LED byte, ACK) with resend/timeout retries and a sticky abort flag.
module ps2_led_cmd_sequencer
  import ps2_led_cmd_sequencer_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [2:0]  INIT_LEDS   = 3'b010,
  parameter bit          SEND_ON_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_data_stb,
  input  logic [7:0] key_data,
  input  logic       key_broken,
  input  logic       rx_done_stb,
  input  logic [7:0] rx_data,
  output logic       rx_enable,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done_stb,
  output logic [2:0] leds,
  output logic       busy,
  output logic       cmd_error
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [2:0]    state, state_nxt;
  logic          pending;
  logic [7:0]    led_byte;
  logic [RW-1:0] retry;
  logic [2:0]    toggle;
  logic          in_wait_tx, in_wait_ack;
  logic          accept, retry_evt, abort;
  logic          tmr_expired;

  assign busy   = (state != ST_IDLE);
  assign toggle = (key_data_stb && !key_broken) ? lock_key_mask(key_data) : 3'b000;

  always_comb begin
    in_wait_tx  = (state == ST_WAIT_TX_CMD) || (state == ST_WAIT_TX_LED);
    in_wait_ack = (state == ST_WAIT_ACK_CMD) || (state == ST_WAIT_ACK_LED);
    accept      = (in_wait_tx && tx_done_stb) ||
                  (in_wait_ack && rx_done_stb && rx_data == PS2_ACK);
    // A received byte in the expiry cycle suppresses the timeout; the saturated
    // timer fires again next cycle if that byte was not useful.
    retry_evt   = (in_wait_tx || in_wait_ack) && !accept &&
                  ((rx_done_stb && rx_data == PS2_RESEND) || (tmr_expired && !rx_done_stb));
    abort       = retry_evt && (retry == RW'(MAX_RETRY));

    state_nxt = state;
    case (state)
      ST_IDLE:     if (pending) state_nxt = ST_SEND_CMD;
      ST_SEND_CMD: state_nxt = ST_WAIT_TX_CMD;
      ST_SEND_LED: state_nxt = ST_WAIT_TX_LED;
      ST_WAIT_TX_CMD, ST_WAIT_ACK_CMD: begin
        if (accept)         state_nxt = in_wait_tx ? ST_WAIT_ACK_CMD : ST_SEND_LED;
        else if (retry_evt) state_nxt = abort ? ST_IDLE : ST_SEND_CMD;
      end
      ST_WAIT_TX_LED, ST_WAIT_ACK_LED: begin
        if (accept)         state_nxt = in_wait_tx ? ST_WAIT_ACK_LED : ST_IDLE;
        else if (retry_evt) state_nxt = abort ? ST_IDLE : ST_SEND_LED;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  ps2_timeout_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_nxt != state),
    .enable  (in_wait_tx || in_wait_ack),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pending   <= SEND_ON_RST;
      leds      <= INIT_LEDS;
      led_byte  <= 8'h00;
      retry     <= '0;
      rx_enable <= 1'b1;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      cmd_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= 1'b0;
      leds     <= leds ^ toggle;

      if (|toggle)               pending <= 1'b1;
      else if (state == ST_IDLE) pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          retry <= '0;
          if (pending) led_byte <= {5'b00000, leds};
        end
        ST_SEND_CMD: begin
          tx_start  <= 1'b1;
          tx_data   <= PS2_CMD_SET_LEDS;
          rx_enable <= 1'b0;
        end
        ST_SEND_LED: begin
          tx_start  <= 1'b1;
          tx_data   <= led_byte;
          rx_enable <= 1'b0;
        end
        default: begin
          if (accept) begin
            if (in_wait_tx) begin
              rx_enable <= 1'b1;
            end else begin
              retry <= '0;
              if (state == ST_WAIT_ACK_LED) cmd_error <= 1'b0;
            end
          end else if (abort) begin
            cmd_error <= 1'b1;
            rx_enable <= 1'b1;
            retry     <= '0;
          end else if (retry_evt) begin
            retry <= retry + RW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_led_cmd_sequencer.sv
// Directed bench for the PS/2 LED sequencer; ACK_TIMEOUT shortened to 64 cycles.
module tb_ps2_led_cmd_sequencer;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_data_stb = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_broken = 1'b0;
  logic       rx_done_stb = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_enable;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_stb = 1'b0;
  logic [2:0] leds;
  logic       busy;
  logic       cmd_error;

  int ntests = 0;
  int nfail  = 0;
  int cyc_cnt = 0;

  ps2_led_cmd_sequencer #(
    .ACK_TIMEOUT(TMO), .MAX_RETRY(3), .INIT_LEDS(3'b010), .SEND_ON_RST(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .key_data_stb(key_data_stb), .key_data(key_data), .key_broken(key_broken),
    .rx_done_stb(rx_done_stb), .rx_data(rx_data), .rx_enable(rx_enable),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done_stb(tx_done_stb),
    .leds(leds), .busy(busy), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic wait_tx(output logic [7:0] d, output int cyc, output bit ok);
    ok = 1'b0; d = 8'h00; cyc = 0;
    while (!ok && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        ok = 1'b1;
        d  = tx_data;
      end
    end
  endtask

  task automatic tx_done;
    tx_done_stb = 1'b1;
    @(negedge clk);
    tx_done_stb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_done_stb = 1'b1; rx_data = b;
    @(negedge clk);
    rx_done_stb = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_key(input logic [7:0] code, input logic brk);
    key_data_stb = 1'b1; key_data = code; key_broken = brk;
    @(negedge clk);
    key_data_stb = 1'b0; key_data = 8'h00; key_broken = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ntests++; if (rx_enable !== 1'b1) begin nfail++; $display("FAIL reset_rx_enable: got %b, expected 1", rx_enable); end
    ntests++; if (tx_start !== 1'b0) begin nfail++; $display("FAIL reset_tx_start: got %b, expected 0", tx_start); end
    ntests++; if (tx_data !== 8'h00) begin nfail++; $display("FAIL reset_tx_data: got %h, expected 00", tx_data); end
    ntests++; if (leds !== 3'b010) begin nfail++; $display("FAIL reset_leds: got %b, expected 010", leds); end
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    ntests++; if (cmd_error !== 1'b0) begin nfail++; $display("FAIL reset_cmd_error: got %b, expected 0", cmd_error); end
  endtask

  task automatic test_power_on;
    logic [7:0] d; int c; bit ok;
    rst = 1'b0;
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'hED) begin nfail++; $display("FAIL por_cmd_byte: got %h (seen=%0d), expected ed", d, ok); end
    ntests++; if (c !== 2) begin nfail++; $display("FAIL por_latency: got %0d, expected 2", c); end
    ntests++; if (rx_enable !== 1'b0) begin nfail++; $display("FAIL por_rx_disabled: got %b, expected 0", rx_enable); end
    tx_done();
    ntests++; if (rx_enable !== 1'b1) begin nfail++; $display("FAIL por_rx_reenabled: got %b, expected 1", rx_enable); end
    send_rx(8'hFA);
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'h02) begin nfail++; $display("FAIL por_led_byte: got %h (seen=%0d), expected 02", d, ok); end
    tx_done();
    send_rx(8'hFA);
    ntests++; if (busy !== 1'b0 || leds !== 3'b010) begin nfail++; $display("FAIL por_done: got busy=%b leds=%b, expected busy=0 leds=010", busy, leds); end
  endtask

  task automatic test_caps;
    logic [7:0] d; int c; bit ok; int starts;
    send_key(8'h58, 1'b0);
    ntests++; if (leds !== 3'b110) begin nfail++; $display("FAIL caps_leds: got %b, expected 110", leds); end
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'hED) begin nfail++; $display("FAIL caps_cmd: got %h (seen=%0d), expected ed", d, ok); end
    tx_done(); send_rx(8'hFA);
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'h06) begin nfail++; $display("FAIL caps_led_byte: got %h (seen=%0d), expected 06", d, ok); end
    tx_done(); send_rx(8'hFA);
    send_key(8'h58, 1'b1);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start || busy) starts++;
    end
    ntests++; if (starts !== 0 || leds !== 3'b110) begin nfail++; $display("FAIL break_ignored: got activity=%0d leds=%b, expected 0 and 110", starts, leds); end
  endtask

  task automatic test_resend;
    logic [7:0] d; int c; bit ok; int cmds;
    send_key(8'h7E, 1'b0);
    cmds = 0;
    for (int i = 0; i < 3; i++) begin
      wait_tx(d, c, ok);
      if (ok && d === 8'hED) cmds++;
      tx_done();
      send_rx((i < 2) ? 8'hFE : 8'hFA);
    end
    ntests++; if (cmds !== 3) begin nfail++; $display("FAIL resend_cmd_count: got %0d, expected 3", cmds); end
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'h07) begin nfail++; $display("FAIL resend_led_byte: got %h (seen=%0d), expected 07", d, ok); end
    tx_done(); send_rx(8'hFA);
    ntests++; if (cmd_error !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL resend_done: got err=%b busy=%b, expected 0 0", cmd_error, busy); end
  endtask

  task automatic test_timeout;
    logic [7:0] d; int c; bit ok; int t_prev, idle_at;
    send_key(8'h7E, 1'b0);
    wait_tx(d, c, ok);
    tx_done(); send_rx(8'hFA);
    wait_tx(d, c, ok);
    t_prev = cyc_cnt;
    ntests++; if (!ok || d !== 8'h06) begin nfail++; $display("FAIL tmo_first_led: got %h (seen=%0d), expected 06", d, ok); end
    tx_done();
    // tx_done one cycle after tx_start: gap = 1 + TMO timer cycles + SEND + start = TMO+3.
    for (int i = 0; i < 3; i++) begin
      wait_tx(d, c, ok);
      ntests++; if (!ok || d !== 8'h06 || cyc_cnt - t_prev !== TMO + 3) begin
        nfail++; $display("FAIL tmo_resend%0d: got byte=%h gap=%0d, expected 06 gap=%0d", i, d, cyc_cnt - t_prev, TMO + 3);
      end
      t_prev = cyc_cnt;
      tx_done();
    end
    idle_at = 0;
    for (int i = 1; i <= 200 && idle_at == 0; i++) begin
      @(negedge clk);
      if (!busy) idle_at = i;
    end
    ntests++; if (idle_at !== TMO + 1) begin nfail++; $display("FAIL tmo_abort_time: got %0d, expected %0d", idle_at, TMO + 1); end
    ntests++; if (cmd_error !== 1'b1 || rx_enable !== 1'b1 || leds !== 3'b110) begin
      nfail++; $display("FAIL tmo_abort_state: got err=%b rx_en=%b leds=%b, expected 1 1 110", cmd_error, rx_enable, leds);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d; int c; bit ok;
    send_key(8'h58, 1'b0);
    wait_tx(d, c, ok);
    tx_done(); send_rx(8'hFA);
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'h02) begin nfail++; $display("FAIL b2b_first_led: got %h (seen=%0d), expected 02", d, ok); end
    tx_done();
    send_key(8'h77, 1'b0);
    send_rx(8'hFA);
    ntests++; if (cmd_error !== 1'b0 || leds !== 3'b000) begin nfail++; $display("FAIL b2b_after_first: got err=%b leds=%b, expected 0 000", cmd_error, leds); end
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'hED || c !== 2) begin nfail++; $display("FAIL b2b_second_cmd: got %h after %0d, expected ed after 2", d, c); end
    tx_done(); send_rx(8'hFA);
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'h00) begin nfail++; $display("FAIL b2b_second_led: got %h (seen=%0d), expected 00", d, ok); end
    tx_done(); send_rx(8'hFA);
  endtask

  task automatic test_reset_midflight;
    logic [7:0] d; int c; bit ok; int starts;
    send_key(8'h7E, 1'b0);
    wait_tx(d, c, ok);
    tx_done(); send_rx(8'hFA);
    wait_tx(d, c, ok);
    ntests++; if (!ok || d !== 8'h01) begin nfail++; $display("FAIL rstmf_led_byte: got %h (seen=%0d), expected 01", d, ok); end
    rst = 1'b1;
    @(negedge clk);
    ntests++; if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || rx_enable !== 1'b1 || leds !== 3'b010 || cmd_error !== 1'b0) begin
      nfail++; $display("FAIL rstmf_values: got busy=%b start=%b data=%h rx_en=%b leds=%b err=%b, expected 0 0 00 1 010 0",
                        busy, tx_start, tx_data, rx_enable, leds, cmd_error);
    end
    starts = 0;
    repeat (2) begin @(negedge clk); if (tx_start) starts++; end
    rst = 1'b0;
    wait_tx(d, c, ok);
    ntests++; if (starts !== 0 || !ok || d !== 8'hED || c !== 2) begin
      nfail++; $display("FAIL rstmf_restart: got stray=%0d byte=%h after %0d, expected 0 ed after 2", starts, d, c);
    end
    tx_done(); send_rx(8'hFA);
    wait_tx(d, c, ok);
    tx_done(); send_rx(8'hFA);
    ntests++; if (!ok || d !== 8'h02 || busy !== 1'b0) begin nfail++; $display("FAIL rstmf_finish: got %h busy=%b, expected 02 0", d, busy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_power_on();
    test_caps();
    test_resend();
    test_timeout();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
